// File: rtl/mic_rx_pkg.sv
// mic_rx_pkg: shared types and parameter defaults for the multi-line I2S
// microphone receiver.
//   rx_state_t    : frame alignment FSM states (HUNT, LEFT, RIGHT)
//   *_DEF         : default generics used by the interface, top and bench
//   chan_idx()    : maps (line, right) to the channel field index
package mic_rx_pkg;

  localparam int N_LINES_DEF     = 3;
  localparam int SLOT_W_DEF      = 32;
  localparam int DATA_W_DEF      = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FRAME_CNT_W     = 16;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_t;

  // Channel 2i is line i left, channel 2i+1 is line i right.
  function automatic int chan_idx(input int line, input bit right);
    return 2 * line + (right ? 1 : 0);
  endfunction

endpackage

// File: rtl/mic_array_rx_if.sv
// mic_array_rx_if: parallel frame output bundle of the microphone receiver.
//   frame_data  : 2*N_LINES channel fields of DATA_W bits, channel k at
//                 [k*DATA_W +: DATA_W]
//   frame_valid : one-cycle strobe, frame_data/frame_cnt just updated
//   frame_err   : one-cycle strobe, a malformed frame was discarded
//   frame_cnt   : number of valid frames since reset (wraps)
// master = receiver side (drives), slave = consumer side.
interface mic_array_rx_if
  import mic_rx_pkg::*;
#(
  parameter int N_LINES = N_LINES_DEF,
  parameter int DATA_W  = DATA_W_DEF
);

  logic [2*N_LINES*DATA_W-1:0] frame_data;
  logic                        frame_valid;
  logic                        frame_err;
  logic [FRAME_CNT_W-1:0]      frame_cnt;

  modport master (
    output frame_data,
    output frame_valid,
    output frame_err,
    output frame_cnt
  );

  modport slave (
    input frame_data,
    input frame_valid,
    input frame_err,
    input frame_cnt
  );

endinterface

// File: rtl/mic_edge_sync.sv
// mic_edge_sync: brings the asynchronous I2S pins into the clk domain.
//   clk, rst_n : system clock, synchronous active-low reset
//   sck        : raw bit clock pin
//   din        : raw companion pins (ws, sd lines) sampled alongside sck
//   dout       : synchronised companion pins, aligned with rise
//   rise       : one-cycle pulse per synchronised sck rising edge
// sck and the data pins travel through the same number of flops so the
// ws/sd values presented with rise are the ones that were stable at the
// pin-level sck rise.
module mic_edge_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sck,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         rise
);

  // Bit 0 of every stage carries sck, the rest carry din.
  logic [W:0]   sync_reg [STAGES];
  logic         sck_d_reg;
  logic         rise_reg;
  logic [W-1:0] dout_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_reg[s] <= '0;
      end
      sck_d_reg <= 1'b0;
      rise_reg  <= 1'b0;
      dout_reg  <= '0;
    end else begin
      sync_reg[0] <= {din, sck};
      for (int s = 1; s < STAGES; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
      // Compare the synchroniser output against its one-cycle delay.
      sck_d_reg <= sync_reg[STAGES-1][0];
      rise_reg  <= sync_reg[STAGES-1][0] & ~sck_d_reg;
      dout_reg  <= sync_reg[STAGES-1][W:1];
    end
  end

  assign dout = dout_reg;
  assign rise = rise_reg;

endmodule

// File: rtl/mic_array_rx.sv
// mic_array_rx: N_LINES-line I2S microphone receiver.
//   clk, rst_n   : system clock (>= 4x mic_sck), synchronous active-low reset
//   mic_sck      : shared I2S bit clock (asynchronous)
//   mic_ws       : shared word select, 0 = left, 1 = right
//   mic_sd       : one serial data bit per line
//   ch_en        : per-channel enable, bit 2i = line i left, 2i+1 = right
//   rx (master)  : frame_data / frame_valid / frame_err / frame_cnt
// Each full left+right pair with exactly SLOT_W bits per slot is emitted as
// one parallel frame; malformed frames raise frame_err instead.
module mic_array_rx
  import mic_rx_pkg::*;
#(
  parameter int N_LINES     = N_LINES_DEF,
  parameter int SLOT_W      = SLOT_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mic_sck,
  input  logic                 mic_ws,
  input  logic [N_LINES-1:0]   mic_sd,
  input  logic [2*N_LINES-1:0] ch_en,
  mic_array_rx_if.master       rx
);

  localparam int FRAME_W = 2 * N_LINES * DATA_W;
  localparam int CNT_W   = $clog2(SLOT_W + 2);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W + 1);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);

  // ---------------------------------------------------------------------
  // Pin synchronisation: bus bit 0 = ws, bits N_LINES:1 = sd lines.
  // ---------------------------------------------------------------------
  logic [N_LINES:0]   bus_s;
  logic               sck_rise;
  logic               ws_s;
  logic [N_LINES-1:0] sd_s;

  mic_edge_sync #(
    .W      (N_LINES + 1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sck   (mic_sck),
    .din   ({mic_sd, mic_ws}),
    .dout  (bus_s),
    .rise  (sck_rise)
  );

  assign ws_s = bus_s[0];
  assign sd_s = bus_s[N_LINES:1];

  // ---------------------------------------------------------------------
  // Slot tracking
  // ---------------------------------------------------------------------
  rx_state_t              state_reg, state_next;
  logic                   ws_prev_reg;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic [CNT_W-1:0]       bit_cnt_inc;
  logic                   err_l_reg;
  logic                   boundary;
  logic                   ws_fall;
  logic                   ws_rise;
  logic                   slot_ok;
  logic                   take_bit;
  logic                   close_left;
  logic                   close_right;
  logic                   frame_good;

  logic [FRAME_W-1:0]     frame_data_reg;
  logic                   frame_valid_reg;
  logic                   frame_err_reg;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;
  logic [FRAME_W-1:0]     frame_word;

  // The edge where ws changes still carries the LSB of the closing slot,
  // so that bit is counted and shifted before the slot is judged.
  assign boundary    = sck_rise && (ws_s != ws_prev_reg);
  assign ws_fall     = boundary && !ws_s;
  assign ws_rise     = boundary && ws_s;
  assign bit_cnt_inc = (bit_cnt_reg == CNT_MAX) ? bit_cnt_reg : bit_cnt_reg + 1'b1;
  assign slot_ok     = (bit_cnt_inc == CNT_SLOT);
  assign take_bit    = (bit_cnt_reg < CNT_DATA);
  assign frame_good  = close_right && !err_l_reg && slot_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    close_left  = 1'b0;
    close_right = 1'b0;
    case (state_reg)
      HUNT: begin
        // Only a 1->0 boundary marks the start of a left slot.
        if (ws_fall) begin
          state_next = LEFT;
        end
      end
      LEFT: begin
        if (ws_rise) begin
          close_left = 1'b1;
          state_next = RIGHT;
        end
      end
      RIGHT: begin
        if (ws_fall) begin
          close_right = 1'b1;
          state_next  = LEFT;
        end
      end
      default: begin
        state_next = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ws_prev_reg <= 1'b0;
      bit_cnt_reg <= '0;
      err_l_reg   <= 1'b0;
    end else if (sck_rise) begin
      ws_prev_reg <= ws_s;
      bit_cnt_reg <= boundary ? '0 : bit_cnt_inc;
      if (close_left) begin
        err_l_reg <= !slot_ok;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-line shift and hold registers, plus channel field assembly
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_LINES; gi++) begin : g_line
      logic [DATA_W-1:0] shift_reg;
      logic [DATA_W-1:0] shift_next;
      logic [DATA_W-1:0] left_hold_reg;

      // Bits past DATA_W are counted but not captured.
      assign shift_next = take_bit ? {shift_reg[DATA_W-2:0], sd_s[gi]} : shift_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          shift_reg     <= '0;
          left_hold_reg <= '0;
        end else if (sck_rise) begin
          shift_reg <= boundary ? '0 : shift_next;
          if (close_left) begin
            left_hold_reg <= shift_next;
          end
        end
      end

      // Right field takes shift_next so the closing LSB is included.
      assign frame_word[chan_idx(gi, 1'b0)*DATA_W +: DATA_W] =
        ch_en[chan_idx(gi, 1'b0)] ? left_hold_reg : '0;
      assign frame_word[chan_idx(gi, 1'b1)*DATA_W +: DATA_W] =
        ch_en[chan_idx(gi, 1'b1)] ? shift_next : '0;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_data_reg  <= '0;
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      frame_valid_reg <= frame_good;
      frame_err_reg   <= close_right && !frame_good;
      if (frame_good) begin
        frame_data_reg <= frame_word;
        frame_cnt_reg  <= frame_cnt_reg + 1'b1;
      end
    end
  end

  assign rx.frame_data  = frame_data_reg;
  assign rx.frame_valid = frame_valid_reg;
  assign rx.frame_err   = frame_err_reg;
  assign rx.frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_mic_array_rx.sv
// tb_mic_array_rx: directed bench for mic_array_rx with a scoreboard of
// expected frame strobes; every strobe is popped and compared.
module tb_mic_array_rx;
  import mic_rx_pkg::*;

  localparam int NL   = 3;
  localparam int SW   = 32;
  localparam int DW   = 16;
  localparam int FW   = 2 * NL * DW;
  localparam int HALF = 40;

  typedef struct {
    bit                     is_err;
    logic [FW-1:0]          data;
    logic [FRAME_CNT_W-1:0] cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mic_sck = 1'b0;
  logic            mic_ws = 1'b1;
  logic [NL-1:0]   mic_sd = '0;
  logic [2*NL-1:0] ch_en = '1;

  mic_array_rx_if #(.N_LINES(NL), .DATA_W(DW)) rx_if ();

  mic_array_rx #(
    .N_LINES     (NL),
    .SLOT_W      (SW),
    .DATA_W      (DW),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mic_sck (mic_sck),
    .mic_ws  (mic_ws),
    .mic_sd  (mic_sd),
    .ch_en   (ch_en),
    .rx      (rx_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t q[$];

  logic [FW-1:0]          model_data = '0;
  logic [FRAME_CNT_W-1:0] model_cnt = '0;
  logic [2*NL-1:0]        ch_en_model = '1;
  logic [NL-1:0]          pending = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: one line per transaction.
  always @(negedge clk) begin
    if (rst_n && (rx_if.frame_valid || rx_if.frame_err)) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", {rx_if.frame_valid, rx_if.frame_err}, 2'b00);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("frame strobe valid=%0d err=%0d cnt=%0h data=%h",
                 rx_if.frame_valid, rx_if.frame_err, rx_if.frame_cnt, rx_if.frame_data);
        chk("kind", {rx_if.frame_valid, rx_if.frame_err}, e.is_err ? 2'b01 : 2'b10);
        chk("frame_data", rx_if.frame_data, e.data);
        chk("frame_cnt", rx_if.frame_cnt, e.cnt);
      end
    end
  end

  task automatic send_edge(input logic ws, input logic [NL-1:0] sd);
    mic_ws = ws;
    mic_sd = sd;
    #HALF mic_sck = 1'b1;
    #HALF mic_sck = 1'b0;
  endtask

  // One ws region of nbits edges; the first edge carries the previous
  // slot's LSB (one-bit I2S delay). Bits past DW are filled with 1.
  task automatic send_slot(input logic ws, input logic [NL*DW-1:0] vals, input int nbits);
    for (int j = 0; j < nbits; j++) begin
      send_edge(ws, pending);
      if (j == 0) ch_en = ch_en_model;
      for (int i = 0; i < NL; i++) begin
        pending[i] = (j < DW) ? vals[i*DW + DW-1-j] : 1'b1;
      end
    end
  endtask

  task automatic push_frame(input logic [NL*DW-1:0] lv, input logic [NL*DW-1:0] rv, input bit good);
    exp_t e;
    if (good) begin
      for (int i = 0; i < NL; i++) begin
        model_data[(2*i)*DW +: DW]   = ch_en_model[2*i]   ? lv[i*DW +: DW] : '0;
        model_data[(2*i+1)*DW +: DW] = ch_en_model[2*i+1] ? rv[i*DW +: DW] : '0;
      end
      model_cnt = model_cnt + 1'b1;
    end
    e.is_err = !good;
    e.data   = model_data;
    e.cnt    = model_cnt;
    q.push_back(e);
  endtask

  task automatic send_frame(input logic [NL*DW-1:0] lv, input logic [NL*DW-1:0] rv,
                            input int lbits, input int rbits);
    send_slot(1'b0, lv, lbits);
    send_slot(1'b1, rv, rbits);
    push_frame(lv, rv, (lbits == SW) && (rbits == SW));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, rx_if.frame_data, '0);
    chk({tag, "_valid"}, rx_if.frame_valid, 1'b0);
    chk({tag, "_err"}, rx_if.frame_err, 1'b0);
    chk({tag, "_cnt"}, rx_if.frame_cnt, '0);
  endtask

  function automatic logic [NL*DW-1:0] pattern(input logic [DW-1:0] base);
    logic [NL*DW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*DW +: DW] = base + DW'(i);
    return v;
  endfunction

  function automatic logic [NL*DW-1:0] rnd_vals();
    logic [NL*DW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  logic [NL*DW-1:0] lv, rv;
  logic [NL*DW-1:0] zero_vals = '0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Start mid-right slot: partial ws=1 region, ignored while hunting
    send_slot(1'b1, zero_vals, 12);

    // Basic frame then a random frame
    lv = pattern(16'h1230);
    rv = pattern(16'hA560);
    send_frame(lv, rv, SW, SW);
    send_frame(rnd_vals(), rnd_vals(), SW, SW);

    // Short left slot -> error, then recovery
    send_frame(rnd_vals(), rnd_vals(), SW-1, SW);
    send_frame(pattern(16'h7F00), pattern(16'h8001), SW, SW);

    // Short right slot -> error
    send_frame(pattern(16'h0101), pattern(16'h0202), SW, SW-2);

    // Channel enables: channels 1 and 4 disabled
    ch_en_model = 6'b101101;
    send_frame(pattern(16'hFFF0), pattern(16'h5550), SW, SW);
    ch_en_model = '1;
    send_frame(rnd_vals(), rnd_vals(), SW, SW);

    // Reset mid left slot
    send_slot(1'b0, pattern(16'h4444), 10);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("midreset");
    q.delete();
    model_data = '0;
    model_cnt  = '0;
    pending    = '0;
    send_slot(1'b0, pattern(16'h4444), SW-10);
    send_slot(1'b1, rnd_vals(), SW);
    send_frame(pattern(16'h2468), pattern(16'h1357), SW, SW);

    // Counter wrap: preload 0xFFFF mid-frame
    lv = rnd_vals();
    rv = rnd_vals();
    send_slot(1'b0, lv, SW);
    force dut.frame_cnt_reg = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_reg;
    model_cnt = 16'hFFFF;
    send_slot(1'b1, rv, SW);
    push_frame(lv, rv, 1'b1);
    send_frame(pattern(16'h0F0F), pattern(16'hF0F0), SW, SW);

    // Closing edges for the last frame, then drain the scoreboard
    send_slot(1'b0, zero_vals, 4);
    for (int t = 0; t < 2000 && q.size() != 0; t++) @(negedge clk);
    chk("drain_pending", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
